key_input_cond: RTL and testbench
=================================

Name: key_input_cond

Overview:
- Input-side conditioner for the count game.
- Takes the raw push-buttons (btn0 start, btn7 restart, spares) and the 8 raw DIP switches.
- Outputs debounced levels, one-cycle press/release/long-press pulses and a debounced switch bank with change strobe.
- The game state machine, LED guess compare and sw7 enable consume these clean events instead of raw pins.

Parameters:
- N_BTN, 8, number of button channels.
- N_SW, 8, number of switch channels.
- TICK_DIV, 1000, clk cycles per sample tick (1 ms at 1 MHz); legal range >= 1.
- DEB_TICKS, 20, consecutive differing ticks required to accept a new level; legal range >= 1.
- LONG_TICKS, 1000, ticks a button must stay debounced-high before btn_long fires; legal range > DEB_TICKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw buttons, 1 = pressed, asynchronous to clk.
- sw_raw  in  N_SW  raw switches, 1 = on, asynchronous to clk.
- btn_level  out  N_BTN  debounced button state.
- btn_press  out  N_BTN  one-cycle pulse on accepted 0->1.
- btn_release  out  N_BTN  one-cycle pulse on accepted 1->0.
- btn_long  out  N_BTN  one-cycle pulse, once per hold, at LONG_TICKS.
- sw_level  out  N_SW  debounced switch state.
- sw_change  out  1  one-cycle pulse when any sw_level bit changes.
- tick  out  1  sample strobe, exported for other timers.

Behaviour:
- Reset (rst=0, async): all outputs 0; synchronizers, prescaler and all counters 0. Release is taken on the next clk edge; the first tick follows TICK_DIV cycles later.
- Synchronizer: 2-flop per input bit, so raw-to-sync latency is 2 cycles. Debounce logic reads only the synchronized value.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle when count==TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- Debounce, per channel, buttons and switches identical. Evaluated only in tick cycles:
  - If sync==level: deb_cnt<=0.
  - Else if deb_cnt==DEB_TICKS-1: level<=sync and deb_cnt<=0.
  - Else deb_cnt<=deb_cnt+1.
  - A glitch shorter than DEB_TICKS ticks is fully rejected, and any agreeing tick restarts the count.
  - deb_cnt width is clog2(DEB_TICKS)+1 and never exceeds DEB_TICKS-1.
- Pulses are registered and rise on the same edge as the level change:
  - btn_press asserts with btn_level 0->1; btn_release asserts with btn_level 1->0.
  - Each pulse lasts one clk cycle, independent of TICK_DIV.
- Long-press FSM, per button, states UP / HELD / LONG:
  - UP -> HELD on press, hold_cnt<=0.
  - HELD: hold_cnt increments each tick. When hold_cnt reaches LONG_TICKS-1 on a tick, move to LONG and pulse btn_long for one cycle.
  - LONG: hold_cnt frozen, no further btn_long.
  - HELD or LONG -> UP on release, hold_cnt<=0.
  - A release takes priority over reaching LONG on the same tick, so no btn_long is issued.
- sw_change = OR of all per-switch accepted transitions, pulsed in the cycle sw_level updates. Several switches changing on the same tick give a single pulse.
- Channels are fully independent. Simultaneous press on btn0 and btn7 gives both btn_press bits in the same cycle, and arbitration is left to the consumer.
- Worst-case latency from a stable raw edge to the pulse is 2 + TICK_DIV*DEB_TICKS cycles.
- A reset asserted mid-debounce or mid-hold discards all state, and no pulse is emitted on reset or release.

Test Plan (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8):
- Reset, then btn_raw[0]=1 held steady -> btn_level[0] rises with a single btn_press[0] pulse within 2+12 cycles; no other bit moves.
- btn_raw[7] high for 2 ticks, then low -> btn_level[7] stays 0, with no press and no release.
- Hold btn_raw[0]=1 for 40 ticks -> exactly one btn_long[0], 8 ticks after btn_press[0]. Release -> btn_release[0]; re-press restarts the long count.
- sw_raw 0x00->0x81, changing on a single cycle -> sw_level=0x81 and exactly one sw_change pulse.
- sw_raw 0x00->0x81, with the two bits changing 1 tick apart -> two sw_change pulses.
- Bounce btn_raw[0] 1/0 every 5 cycles for 60 cycles, then steady 1 -> no pulses during the bounce, then one press.
- Reset at tick 2 of a debounce -> all outputs 0 immediately. After release, a steady input needs the full 3 ticks again.
- TICK_DIV=1 -> tick is constantly high, and the press occurs 2+3 cycles after the raw edge.

Source files
------------

// File: rtl/key_input_cond_if.sv
// Bundle of raw inputs and conditioned outputs for the key/switch conditioner.
// master: the raw pin source (drives btn_raw/sw_raw, observes clean events).
// slave : the conditioner (reads raw pins, drives levels, pulses and tick).
interface key_input_cond_if #(
    parameter int unsigned N_BTN = 8,
    parameter int unsigned N_SW  = 8
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [N_SW-1:0]  sw_level;
    logic             sw_change;
    logic             tick;

    modport master (
        output btn_raw, sw_raw,
        input  btn_level, btn_press, btn_release, btn_long, sw_level, sw_change, tick
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_level, btn_press, btn_release, btn_long, sw_level, sw_change, tick
    );
endinterface

// File: rtl/key_input_cond.sv
// Input conditioner for the count game: synchronizes and debounces raw buttons
// and switches, and produces one-cycle press/release/long-press pulses, a
// debounced switch bank with a change strobe, and the shared sample tick.
// Ports: clk, rst (async, active-low), bus (key_input_cond_if.slave):
//   in  btn_raw, sw_raw
//   out btn_level, btn_press, btn_release, btn_long, sw_level, sw_change, tick
module key_input_cond #(
    parameter int unsigned N_BTN      = 8,
    parameter int unsigned N_SW       = 8,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned DEB_TICKS  = 20,
    parameter int unsigned LONG_TICKS = 1000
) (
    input  logic           clk,
    input  logic           rst,
    key_input_cond_if.slave bus
);
    localparam int unsigned N_CH = N_BTN + N_SW;
    localparam int unsigned DW   = $clog2(DEB_TICKS) + 1;
    localparam int unsigned HW   = $clog2(LONG_TICKS);
    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {ST_UP, ST_HELD, ST_LONG} hold_state_e;

    // Buttons occupy the low channels, switches the high ones.
    logic [N_CH-1:0]          raw_c;
    logic [N_CH-1:0]          sync1_q, sync2_q;
    logic [N_CH-1:0]          level_q, level_d;
    logic [N_CH-1:0]          rise_c, fall_c;
    logic [N_CH-1:0][DW-1:0]  deb_q, deb_d;
    logic [TW-1:0]            div_q, div_d;
    logic                     tick_q;
    hold_state_e              st_q [N_BTN];
    hold_state_e              st_d [N_BTN];
    logic [N_BTN-1:0][HW-1:0] hold_q, hold_d;
    logic [N_BTN-1:0]         long_c;
    logic [N_BTN-1:0]         press_q, release_q, long_q;
    logic                     sw_change_q;

    assign raw_c = {bus.sw_raw, bus.btn_raw};

    // Prescaler; tick is registered so it reads 0 while in reset.
    always_comb begin
        div_d = (div_q == TW'(TICK_DIV - 1)) ? '0 : div_q + TW'(1);
    end

    // Debounce: only tick cycles advance or restart the disagreement count.
    always_comb begin
        level_d = level_q;
        deb_d   = deb_q;
        rise_c  = '0;
        fall_c  = '0;
        if (tick_q) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    deb_d[i] = '0;
                end else if (deb_q[i] == DW'(DEB_TICKS - 1)) begin
                    level_d[i] = sync2_q[i];
                    deb_d[i]   = '0;
                    rise_c[i]  = sync2_q[i];
                    fall_c[i]  = ~sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + DW'(1);
                end
            end
        end
    end

    // Long-press FSM next state; a release on the same tick wins over LONG.
    always_comb begin
        st_d   = st_q;
        hold_d = hold_q;
        long_c = '0;
        for (int unsigned b = 0; b < N_BTN; b++) begin
            case (st_q[b])
                ST_UP: begin
                    if (rise_c[b]) begin
                        st_d[b]   = ST_HELD;
                        hold_d[b] = '0;
                    end
                end
                ST_HELD: begin
                    if (fall_c[b]) begin
                        st_d[b]   = ST_UP;
                        hold_d[b] = '0;
                    end else if (tick_q) begin
                        if (hold_q[b] == HW'(LONG_TICKS - 1)) begin
                            st_d[b]   = ST_LONG;
                            long_c[b] = 1'b1;
                        end else begin
                            hold_d[b] = hold_q[b] + HW'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (fall_c[b]) begin
                        st_d[b]   = ST_UP;
                        hold_d[b] = '0;
                    end
                end
                default: begin
                    st_d[b]   = ST_UP;
                    hold_d[b] = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            level_q     <= '0;
            deb_q       <= '0;
            hold_q      <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            sw_change_q <= 1'b0;
            for (int unsigned b = 0; b < N_BTN; b++) begin
                st_q[b] <= ST_UP;
            end
        end else begin
            sync1_q     <= raw_c;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            tick_q      <= (div_d == TW'(TICK_DIV - 1));
            level_q     <= level_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            press_q     <= rise_c[N_BTN-1:0];
            release_q   <= fall_c[N_BTN-1:0];
            long_q      <= long_c;
            sw_change_q <= |(rise_c[N_CH-1:N_BTN] | fall_c[N_CH-1:N_BTN]);
            for (int unsigned b = 0; b < N_BTN; b++) begin
                st_q[b] <= st_d[b];
            end
        end
    end

    assign bus.btn_level   = level_q[N_BTN-1:0];
    assign bus.sw_level    = level_q[N_CH-1:N_BTN];
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_long    = long_q;
    assign bus.sw_change   = sw_change_q;
    assign bus.tick        = tick_q;
endmodule

// File: tb/tb_key_input_cond.sv
// Bench for key_input_cond: level vector table, hand sequences for the timing
// corner cases, and randomized stimulus against a cycle-level reference model.
module tb_key_input_cond;
    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int LNG = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_input_cond_if #(.N_BTN(8), .N_SW(8)) bif ();
    key_input_cond_if #(.N_BTN(8), .N_SW(8)) bif1 ();

    key_input_cond #(.N_BTN(8), .N_SW(8), .TICK_DIV(DIV), .DEB_TICKS(DEB), .LONG_TICKS(LNG))
        dut (.clk(clk), .rst(rst), .bus(bif.slave));
    key_input_cond #(.N_BTN(8), .N_SW(8), .TICK_DIV(1), .DEB_TICKS(DEB), .LONG_TICKS(LNG))
        dut1 (.clk(clk), .rst(rst), .bus(bif1.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state (cycle-level, counts in plain integers).
    int          n_edges;
    logic [15:0] h1, h2, m_lvl;
    int          dcnt [16];
    bit          held [8];
    int          hticks [8];
    bit          ldone [8];
    logic [7:0]  m_press, m_rel, m_long;
    logic        m_swc, m_tick;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_tick(input int n);
        return (n >= 1) && ((n % DIV) == DIV - 1);
    endfunction

    task automatic model_reset();
        n_edges = 0; h1 = '0; h2 = '0; m_lvl = '0;
        m_press = '0; m_rel = '0; m_long = '0; m_swc = 1'b0; m_tick = 1'b0;
        for (int i = 0; i < 16; i++) dcnt[i] = 0;
        for (int b = 0; b < 8; b++) begin
            held[b] = 1'b0; hticks[b] = 0; ldone[b] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] sync, acc;
        bit tk;
        tk   = is_tick(n_edges);
        sync = h2;
        h2   = h1;
        h1   = {bif.sw_raw, bif.btn_raw};
        acc  = '0;
        m_press = '0; m_rel = '0; m_long = '0;
        if (tk) begin
            for (int c = 0; c < 16; c++) begin
                if (sync[c] !== m_lvl[c]) begin
                    dcnt[c]++;
                    if (dcnt[c] == DEB) begin
                        m_lvl[c] = sync[c];
                        dcnt[c]  = 0;
                        acc[c]   = 1'b1;
                    end
                end else begin
                    dcnt[c] = 0;
                end
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (acc[b] && m_lvl[b]) begin
                m_press[b] = 1'b1; held[b] = 1'b1; hticks[b] = 0; ldone[b] = 1'b0;
            end else if (acc[b]) begin
                m_rel[b] = 1'b1; held[b] = 1'b0;
            end else if (tk && held[b] && !ldone[b]) begin
                hticks[b]++;
                if (hticks[b] == LNG) begin
                    m_long[b] = 1'b1; ldone[b] = 1'b1;
                end
            end
        end
        m_swc = |acc[15:8];
        n_edges++;
        m_tick = is_tick(n_edges);
    endtask

    task automatic compare_all();
        check("btn_level",   32'(bif.btn_level),   32'(m_lvl[7:0]));
        check("sw_level",    32'(bif.sw_level),    32'(m_lvl[15:8]));
        check("btn_press",   32'(bif.btn_press),   32'(m_press));
        check("btn_release", 32'(bif.btn_release), 32'(m_rel));
        check("btn_long",    32'(bif.btn_long),    32'(m_long));
        check("sw_change",   32'(bif.sw_change),   32'(m_swc));
        check("tick",        32'(bif.tick),        32'(m_tick));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    // Called #1 after a posedge; outputs must clear as soon as rst falls.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_tick1", 32'(bif1.tick), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [7:0] btn;
        logic [7:0] sw;
        int         cycles;
        logic [7:0] exp_btn;
        logic [7:0] exp_sw;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int np, nr, nl, nc, p_at, l_at, p2, l2;
        bif.btn_raw = '0; bif.sw_raw = '0;
        bif1.btn_raw = '0; bif1.sw_raw = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Level table: long holds settle, short holds are rejected.
        vecs[0] = '{8'h01, 8'h00, 20, 8'h01, 8'h00};
        vecs[1] = '{8'h00, 8'h81, 20, 8'h00, 8'h81};
        vecs[2] = '{8'h80, 8'h81,  4, 8'h00, 8'h81};
        vecs[3] = '{8'h00, 8'h81,  8, 8'h00, 8'h81};
        vecs[4] = '{8'hA5, 8'h3C, 24, 8'hA5, 8'h3C};
        vecs[5] = '{8'hA5, 8'hC3,  6, 8'hA5, 8'h3C};
        vecs[6] = '{8'hA5, 8'h3C,  8, 8'hA5, 8'h3C};
        vecs[7] = '{8'h00, 8'h00, 24, 8'h00, 8'h00};
        for (int v = 0; v < 8; v++) begin
            bif.btn_raw = vecs[v].btn;
            bif.sw_raw  = vecs[v].sw;
            repeat (vecs[v].cycles) step();
            check($sformatf("vec%0d_btn", v), 32'(bif.btn_level), 32'(vecs[v].exp_btn));
            check($sformatf("vec%0d_sw", v),  32'(bif.sw_level),  32'(vecs[v].exp_sw));
        end

        // btn0 held: press at tick 3, long 8 ticks later, release, re-press.
        do_reset();
        bif.btn_raw = 8'h01;
        np = 0; nl = 0; p_at = -1; l_at = -1;
        for (int i = 1; i <= 160; i++) begin
            step();
            if (bif.btn_press[0]) begin np++; if (p_at < 0) p_at = i; end
            if (bif.btn_long[0])  begin nl++; if (l_at < 0) l_at = i; end
        end
        check("hold_press_cnt", 32'(np), 32'd1);
        check("hold_press_lat", 32'(p_at), 32'd12);
        check("hold_long_cnt", 32'(nl), 32'd1);
        check("hold_long_gap", 32'(l_at - p_at), 32'(LNG * DIV));
        bif.btn_raw = 8'h00;
        nr = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bif.btn_release[0]) nr++;
        end
        check("hold_release_cnt", 32'(nr), 32'd1);
        bif.btn_raw = 8'h01;
        np = 0; nl = 0; p2 = -1; l2 = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bif.btn_press[0]) begin np++; if (p2 < 0) p2 = i; end
            if (bif.btn_long[0])  begin nl++; if (l2 < 0) l2 = i; end
        end
        check("repress_cnt", 32'(np), 32'd1);
        check("repress_long_gap", 32'(l2 - p2), 32'(LNG * DIV));
        check("repress_long_cnt", 32'(nl), 32'd1);

        // btn7 pulse shorter than the debounce window is ignored.
        do_reset();
        bif.btn_raw = 8'h80;
        np = 0;
        repeat (8) begin step(); np += int'(bif.btn_level[7] | bif.btn_press[7] | bif.btn_release[7]); end
        bif.btn_raw = 8'h00;
        repeat (32) begin step(); np += int'(bif.btn_level[7] | bif.btn_press[7] | bif.btn_release[7]); end
        check("short_btn7_events", 32'(np), 32'd0);

        // Two switches changing in the same cycle: one strobe.
        do_reset();
        bif.sw_raw = 8'h81;
        nc = 0;
        repeat (30) begin step(); if (bif.sw_change) nc++; end
        check("sw_same_cycle_chg", 32'(nc), 32'd1);
        check("sw_same_cycle_lvl", 32'(bif.sw_level), 32'h81);

        // Two switches one tick apart: two strobes.
        do_reset();
        bif.sw_raw = 8'h01;
        nc = 0;
        repeat (DIV) begin step(); if (bif.sw_change) nc++; end
        bif.sw_raw = 8'h81;
        repeat (30) begin step(); if (bif.sw_change) nc++; end
        check("sw_split_chg", 32'(nc), 32'd2);
        check("sw_split_lvl", 32'(bif.sw_level), 32'h81);

        // Bouncing btn0 every 5 cycles: silent, then one press once steady.
        do_reset();
        np = 0;
        for (int i = 0; i < 60; i++) begin
            bif.btn_raw = ((i / 5) % 2 == 0) ? 8'h01 : 8'h00;
            step();
            np += int'(bif.btn_press[0] | bif.btn_release[0]);
        end
        check("bounce_quiet", 32'(np), 32'd0);
        bif.btn_raw = 8'h01;
        np = 0;
        repeat (30) begin step(); if (bif.btn_press[0]) np++; end
        check("bounce_then_press", 32'(np), 32'd1);

        // Reset two ticks into a debounce discards the progress.
        do_reset();
        bif.btn_raw = 8'h01;
        repeat (8) step();
        do_reset();
        check("midrst_level", 32'(bif.btn_level), 32'd0);
        p_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bif.btn_press[0] && p_at < 0) p_at = i;
        end
        check("midrst_press_lat", 32'(p_at), 32'd12);

        // TICK_DIV=1 instance: tick always high, press 2+3 cycles after raw edge.
        bif.btn_raw = 8'h00;
        do_reset();
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            check("div1_tick", 32'(bif1.tick), 32'd1);
        end
        bif1.btn_raw = 8'h01;
        p_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bif1.btn_press[0] && p_at < 0) p_at = i;
        end
        check("div1_press_lat", 32'(p_at), 32'd5);
        check("div1_level", 32'(bif1.btn_level), 32'h01);
        bif1.btn_raw = 8'h00;

        // Randomized stimulus against the model, with occasional resets.
        do_reset();
        for (int r = 0; r < 120; r++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 6)      bif.btn_raw[$urandom_range(0, 7)] = ~bif.btn_raw[$urandom_range(0, 7)];
            else if (mode < 8) bif.sw_raw  = bif.sw_raw ^ (8'h01 << $urandom_range(0, 7));
            else begin
                bif.btn_raw = 8'($urandom);
                bif.sw_raw  = 8'($urandom);
            end
            repeat ($urandom_range(1, 48)) step();
            if (r % 40 == 39) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
